phase_accum: RTL
================

Name: phase_accum

Overview:
Pipelined popcount-and-accumulate block for SAR ADC phase vectors. Each valid phase word is reduced to its count of set bits. Counts are summed over a runtime-programmable number of samples (oversampling/decimation), and one averaged-sum result is emitted per frame. It sits between the phase capture logic and the output register/Wishbone readout, replacing the single-shot combinational phase count.

Parameters:
PHASE_WIDTH, 11, width of the phase vector.
SUM_WIDTH, 4, width of the per-sample popcount; must hold PHASE_WIDTH, i.e. ceil(log2(PHASE_WIDTH+1)).
ACC_WIDTH, 16, width of the frame accumulator.
CNT_WIDTH, 8, width of the samples-per-frame setting.

Ports:
clk_i  input  1  system clock; all state changes on the rising edge.
rst_ni  input  1  asynchronous active-low reset.
en_i  input  1  block enable; low returns the block to IDLE.
clear_i  input  1  synchronous clear of the frame in progress and of overflow_o.
phase_i  input  PHASE_WIDTH  phase vector for the current sample.
phase_valid_i  input  1  phase_i is valid this cycle.
num_samples_i  input  CNT_WIDTH  samples per frame; 0 is treated as 1.
sum_o  output  SUM_WIDTH  registered popcount of the last valid sample.
sum_valid_o  output  1  one-cycle pulse; sum_o updated.
acc_o  output  ACC_WIDTH  last completed frame sum; holds until the next frame completes.
acc_valid_o  output  1  one-cycle pulse; acc_o updated.
overflow_o  output  1  sticky; a frame saturated.
busy_o  output  1  a frame is in progress (at least one sample accepted, frame not finished).

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0, accumulator 0, sample counter 0, FSM in IDLE.
- Stage 1: on each edge with en_i=1 and phase_valid_i=1, sum_o takes popcount(phase_i) and sum_valid_o pulses. Latency is 1 cycle.
- Stage 2: consumes stage-1 results. acc_valid_o rises 2 cycles after phase_valid_i of the frame's last sample.
- FSM states:
  - IDLE: en_i=0, or enabled with no sample yet.
  - RUN: frame in progress.
- IDLE to RUN: first stage-1 valid while en_i=1. On that edge, num_samples_i is latched as frame length N (0 is latched as 1). Changes to num_samples_i mid-frame take effect on the next frame.
- In RUN, each stage-1 valid adds sum_o to the accumulator and increments the counter.
- Last sample (counter reaches N):
  - acc_o takes accumulator + sum, saturated.
  - acc_valid_o is high for 1 cycle.
  - accumulator and counter return to 0.
  - FSM goes to IDLE, with busy_o=0 the following cycle.
- Back-to-back frames are supported: a stage-1 valid in the same cycle as frame completion starts the next frame with no lost sample.
- Width rule: the sum is zero-extended to ACC_WIDTH. If a true sum exceeds 2^ACC_WIDTH-1, the accumulator saturates at all-ones and overflow_o is set. It stays set until clear_i or reset.
- clear_i (priority over everything except reset):
  - accumulator, counter, stage-1 valid and overflow_o all go to 0; FSM goes to IDLE.
  - acc_o holds its last value; no acc_valid_o pulse.
  - A phase_valid_i in the same cycle as clear_i is dropped.
- en_i deasserted mid-frame: the partial frame is discarded, as for clear_i, but overflow_o is retained. phase_valid_i is ignored while en_i=0.
- Gaps (phase_valid_i low) within a frame are allowed; state holds.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, RUN).
  - default width constants PHASE_WIDTH_DEF=11, ACC_WIDTH_DEF=16.
  - a function computing SUM_WIDTH from PHASE_WIDTH.
- One natural sub-module: phase_popcount, a parametrised combinational popcount (PHASE_WIDTH in, SUM_WIDTH out), instantiated in stage 1.

Test Plan:
- Popcount check: reset; en_i=1, N=1; phase_i=11'h7FF, then 11'h000, then 11'h555 -> sum_o = 11, 0, 6, each with sum_valid_o one cycle later; acc_o = 11, 0, 6 with acc_valid_o two cycles after each sample.
- Multi-sample frames: N=4, four back-to-back samples of 11'h7FF, then four of 11'h001 -> acc_o = 44 then 4; acc_valid_o pulses exactly twice; busy_o high during each frame.
- Saturation: ACC_WIDTH=6, N=8, all-ones samples -> acc_o = 63 and overflow_o = 1, held through the next frame; clear_i -> overflow_o = 0.
- Clear mid-frame: N=4, two samples of 11'h7FF, then clear_i with a simultaneous valid, then four samples of 11'h003 -> no pulse for the aborted frame; next acc_o = 8.
- N=0 and mid-frame length change: N=0 with one sample 11'h00F -> acc_o = 4 after 1 sample. Then N=3, change to 1 after the first sample -> the frame still closes after 3 samples.
- Async reset mid-frame: rst_ni low between edges during RUN -> all outputs 0 immediately. After release, a new N=2 frame of 11'h7FF gives acc_o = 22.

Source files
------------

// File: rtl/phase_accum_pkg.sv
// Shared types and width helpers for the phase popcount/accumulate block.
package phase_accum_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PHASE_WIDTH_DEF = 11;
  localparam int ACC_WIDTH_DEF   = 16;

  // Bits needed to hold a count of 0..phase_width set bits.
  function automatic int sum_width_for(input int phase_width);
    return $clog2(phase_width + 1);
  endfunction

endpackage

// File: rtl/phase_accum_popcount.sv
// Combinational count of set bits in a phase vector.
module phase_popcount #(
  parameter int PHASE_WIDTH = 11,
  parameter int SUM_WIDTH   = 4
) (
  input  logic [PHASE_WIDTH-1:0] phase_i,
  output logic [SUM_WIDTH-1:0]   count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < PHASE_WIDTH; i++) begin
      count_o = count_o + SUM_WIDTH'(phase_i[i]);
    end
  end

endmodule

// File: rtl/phase_accum.sv
// Two-stage popcount and per-frame saturating accumulator for SAR ADC phase words.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | disabled, or enabled and waiting for the first sample of a frame
//   ST_RUN  | frame in progress, at least one sample accumulated
module phase_accum
  import phase_accum_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int SUM_WIDTH   = sum_width_for(PHASE_WIDTH),
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic [PHASE_WIDTH-1:0] phase_i,
  input  logic                   phase_valid_i,
  input  logic [CNT_WIDTH-1:0]   num_samples_i,
  output logic [SUM_WIDTH-1:0]   sum_o,
  output logic                   sum_valid_o,
  output logic [ACC_WIDTH-1:0]   acc_o,
  output logic                   acc_valid_o,
  output logic                   overflow_o,
  output logic                   busy_o
);

  state_e                 state_q, state_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic                   sum_valid_q, sum_valid_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   acc_out_q, acc_out_d;
  logic                   acc_valid_q, acc_valid_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;

  logic [SUM_WIDTH-1:0]   pop;
  logic [ACC_WIDTH:0]     acc_sum;
  logic [ACC_WIDTH-1:0]   acc_sat;
  logic [CNT_WIDTH-1:0]   frame_len;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   frame_done;

  phase_popcount #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH)
  ) u_popcount (
    .phase_i(phase_i),
    .count_o(pop)
  );

  // The frame length is sampled only when a frame opens; mid-frame edits wait.
  assign frame_len  = (state_q == ST_IDLE)
                      ? ((num_samples_i == '0) ? CNT_WIDTH'(1) : num_samples_i)
                      : len_q;
  assign cnt_next   = cnt_q + CNT_WIDTH'(1);
  assign frame_done = (cnt_next == frame_len);
  assign acc_sum    = {1'b0, acc_q} + (ACC_WIDTH + 1)'(sum_q);
  assign acc_sat    = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = 1'b0;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    len_d       = len_q;

    if (clear_i) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ST_IDLE;
    end else if (!en_i) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      if (phase_valid_i) begin
        sum_d       = pop;
        sum_valid_d = 1'b1;
      end
      if (sum_valid_q) begin
        if (acc_sum[ACC_WIDTH]) begin
          ovf_d = 1'b1;
        end
        if (frame_done) begin
          acc_out_d   = acc_sat;
          acc_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          acc_d   = acc_sat;
          cnt_d   = cnt_next;
          len_d   = frame_len;
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
    end
  end

  assign sum_o       = sum_q;
  assign sum_valid_o = sum_valid_q;
  assign acc_o       = acc_out_q;
  assign acc_valid_o = acc_valid_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q == ST_RUN);

endmodule
